// File: rtl/vector_deserializer_pkg.sv
// Shared vector definitions: component width default, vector width derivation,
// slot indices and the collection state encoding.
package vector_deserializer_pkg;

    localparam int unsigned DEF_COMP_W = 32;
    localparam int unsigned NUM_SLOTS  = 3;

    localparam int unsigned SLOT_X = 0;
    localparam int unsigned SLOT_Y = 1;
    localparam int unsigned SLOT_Z = 2;

    typedef enum logic [1:0] {
        COLLECT_X = 2'd0,
        COLLECT_Y = 2'd1,
        COLLECT_Z = 2'd2
    } state_t;

    // Packed vector width is always derived from the component width.
    function automatic int unsigned vec_width(input int unsigned comp_w);
        return NUM_SLOTS * comp_w;
    endfunction

endpackage

// File: rtl/vector_deserializer_if.sv
// Component-word input stream and packed-vector output stream of the deserializer.
interface vector_deserializer_if
    import vector_deserializer_pkg::*;
#(
    parameter int unsigned COMP_W = DEF_COMP_W
);
    localparam int unsigned VEC_W = vec_width(COMP_W);

    logic              in_valid;
    logic              in_ready;
    logic [COMP_W-1:0] in_data;
    logic              in_last;
    logic              in_neg;
    logic              out_valid;
    logic              out_ready;
    logic [VEC_W-1:0]  out_vec;
    logic              err;

    modport master (
        output in_valid, in_data, in_last, in_neg, out_ready,
        input  in_ready, out_valid, out_vec, err
    );

    modport slave (
        input  in_valid, in_data, in_last, in_neg, out_ready,
        output in_ready, out_valid, out_vec, err
    );

endinterface

// File: rtl/vector_deserializer_comp_negate.sv
// Combinational two's-complement negate of one component; the most negative
// value wraps to itself.
module comp_negate #(
    parameter int unsigned COMP_W = 32
) (
    input  logic              en,
    input  logic [COMP_W-1:0] data,
    output logic [COMP_W-1:0] neg_c
);

    assign neg_c = en ? (~data) + COMP_W'(1) : data;

endmodule

// File: rtl/vector_deserializer.sv
// Collects x, y, z component words into one packed vector, with optional
// negation requested on the x word and framing-error reporting.
module vector_deserializer
    import vector_deserializer_pkg::*;
#(
    parameter int unsigned COMP_W = DEF_COMP_W
) (
    input  logic                  clk,
    input  logic                  rst,
    vector_deserializer_if.slave  bus
);

    localparam int unsigned VEC_W = vec_width(COMP_W);

    state_t            state;
    logic [COMP_W-1:0] stage_x;
    logic [COMP_W-1:0] stage_y;
    logic              neg_q;
    logic              out_valid_q;
    logic [VEC_W-1:0]  out_vec_q;
    logic              err_q;

    logic [COMP_W-1:0] neg_x;
    logic [COMP_W-1:0] neg_y;
    logic [COMP_W-1:0] neg_z;
    logic              accept;

    // z may only be taken when the output slot is free or draining this cycle.
    assign bus.in_ready = (state != COLLECT_Z) || !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    assign bus.out_valid = out_valid_q;
    assign bus.out_vec   = out_vec_q;
    assign bus.err       = err_q;

    comp_negate #(.COMP_W(COMP_W)) u_neg_x (.en(neg_q), .data(stage_x),     .neg_c(neg_x));
    comp_negate #(.COMP_W(COMP_W)) u_neg_y (.en(neg_q), .data(stage_y),     .neg_c(neg_y));
    comp_negate #(.COMP_W(COMP_W)) u_neg_z (.en(neg_q), .data(bus.in_data), .neg_c(neg_z));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= COLLECT_X;
            stage_x     <= '0;
            stage_y     <= '0;
            neg_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_vec_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (accept) begin
                unique case (state)
                    COLLECT_X: begin
                        if (bus.in_last) begin
                            // Early last: drop the partial vector and restart.
                            err_q   <= 1'b1;
                            stage_x <= '0;
                            stage_y <= '0;
                            neg_q   <= 1'b0;
                            state   <= COLLECT_X;
                        end else begin
                            stage_x <= bus.in_data;
                            neg_q   <= bus.in_neg;
                            state   <= COLLECT_Y;
                        end
                    end
                    COLLECT_Y: begin
                        if (bus.in_last) begin
                            err_q   <= 1'b1;
                            stage_x <= '0;
                            stage_y <= '0;
                            neg_q   <= 1'b0;
                            state   <= COLLECT_X;
                        end else begin
                            stage_y <= bus.in_data;
                            state   <= COLLECT_Z;
                        end
                    end
                    COLLECT_Z: begin
                        // Third word always completes the vector; a missing last only flags.
                        out_vec_q[SLOT_X*COMP_W +: COMP_W] <= neg_x;
                        out_vec_q[SLOT_Y*COMP_W +: COMP_W] <= neg_y;
                        out_vec_q[SLOT_Z*COMP_W +: COMP_W] <= neg_z;
                        out_valid_q <= 1'b1;
                        err_q       <= !bus.in_last;
                        state       <= COLLECT_X;
                    end
                    default: begin
                        state <= COLLECT_X;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vector_deserializer.sv
// Directed and randomized checks of vector_deserializer assembly, negation,
// back-pressure, framing errors and reset.
module tb_vector_deserializer;
    import vector_deserializer_pkg::*;

    localparam int unsigned CW = 32;
    localparam int unsigned VW = 96;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass = 0;
    logic err_seen;
    logic [VW-1:0] exp_q[$];

    always #5 clk = ~clk;

    vector_deserializer_if #(.COMP_W(CW)) bus();

    vector_deserializer #(.COMP_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(negedge clk) if (bus.err === 1'b1) err_seen = 1'b1;

    function automatic logic [VW-1:0] pack(input logic [CW-1:0] x, input logic [CW-1:0] y,
                                           input logic [CW-1:0] z, input logic neg);
        logic [CW-1:0] nx, ny, nz;
        nx = neg ? (32'd0 - x) : x;
        ny = neg ? (32'd0 - y) : y;
        nz = neg ? (32'd0 - z) : z;
        return {nz, ny, nx};
    endfunction

    task automatic send_word(input logic [CW-1:0] d, input logic last, input logic neg);
        logic acc;
        bit   done;
        done = 1'b0;
        bus.in_data  = d;
        bus.in_last  = last;
        bus.in_neg   = neg;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) done = 1'b1;
        end
        bus.in_valid = 1'b0;
        if (!done) begin
            n_checks++;
            $display("FAIL send_word timeout data=%h", d);
        end
    endtask

    task automatic send_vec(input logic [CW-1:0] x, input logic [CW-1:0] y,
                            input logic [CW-1:0] z, input logic neg);
        send_word(x, 1'b0, neg);
        send_word(y, 1'b0, 1'b0);
        send_word(z, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.in_neg = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_vec !== 96'd0) $display("FAIL reset_out_vec got %h want 0", bus.out_vec); else n_pass++;
        n_checks++; if (bus.err !== 1'b0) $display("FAIL reset_err got %b want 0", bus.err); else n_pass++;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [VW-1:0] want;
        want = 96'h00000003_00000002_00000001;
        bus.out_ready = 1'b1;
        send_vec(32'd1, 32'd2, 32'd3, 1'b0);
        n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL basic_valid got %b want 1", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_vec !== want) $display("FAIL basic_vec got %h want %h", bus.out_vec, want); else n_pass++;
        n_checks++; if (bus.err !== 1'b0) $display("FAIL basic_err got %b want 0", bus.err); else n_pass++;
        @(posedge clk);
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL basic_drain got %b want 0", bus.out_valid); else n_pass++;
    endtask

    task automatic test_negate();
        logic [VW-1:0] want;
        want = 96'h80000000_00000007_FFFFFFFB;
        send_vec(32'd5, 32'hFFFFFFF9, 32'h80000000, 1'b1);
        n_checks++; if (bus.out_vec !== want) $display("FAIL negate_vec got %h want %h", bus.out_vec, want); else n_pass++;
        // neg on y/z words must be ignored
        want = 96'h00000030_00000020_00000010;
        send_word(32'h10, 1'b0, 1'b0);
        send_word(32'h20, 1'b0, 1'b1);
        send_word(32'h30, 1'b1, 1'b1);
        n_checks++; if (bus.out_vec !== want) $display("FAIL neg_ignored got %h want %h", bus.out_vec, want); else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_stall();
        logic [VW-1:0] va, vb;
        va = 96'h000000A3_000000A2_000000A1;
        vb = 96'h000000B3_000000B2_000000B1;
        bus.out_ready = 1'b1;
        send_vec(32'hA1, 32'hA2, 32'hA3, 1'b0);
        bus.out_ready = 1'b0;
        send_word(32'hB1, 1'b0, 1'b0);
        send_word(32'hB2, 1'b0, 1'b0);
        bus.in_data = 32'hB3; bus.in_last = 1'b1; bus.in_neg = 1'b0; bus.in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL stall_in_ready got %b want 0", bus.in_ready); else n_pass++;
            n_checks++; if (bus.out_vec !== va) $display("FAIL stall_hold got %h want %h", bus.out_vec, va); else n_pass++;
        end
        bus.out_ready = 1'b1;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL stall_release got %b want 1", bus.in_ready); else n_pass++;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL stall_valid got %b want 1", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_vec !== vb) $display("FAIL stall_replace got %h want %h", bus.out_vec, vb); else n_pass++;
        @(posedge clk);
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL stall_drain got %b want 0", bus.out_valid); else n_pass++;
    endtask

    task automatic test_framing();
        logic [VW-1:0] want;
        bus.out_ready = 1'b1;
        send_word(32'd1, 1'b0, 1'b0);
        send_word(32'd2, 1'b1, 1'b0);
        n_checks++; if (bus.err !== 1'b1) $display("FAIL early_last_err got %b want 1", bus.err); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL early_last_valid got %b want 0", bus.out_valid); else n_pass++;
        @(posedge clk);
        #1;
        n_checks++; if (bus.err !== 1'b0) $display("FAIL err_pulse_width got %b want 0", bus.err); else n_pass++;
        want = 96'h00000007_00000008_00000009;
        send_vec(32'd9, 32'd8, 32'd7, 1'b0);
        n_checks++; if (bus.out_vec !== want) $display("FAIL after_err_vec got %h want %h", bus.out_vec, want); else n_pass++;
        // missing last on third word still completes the vector
        want = 96'h00000013_00000012_00000011;
        send_word(32'h11, 1'b0, 1'b0);
        send_word(32'h12, 1'b0, 1'b0);
        send_word(32'h13, 1'b0, 1'b0);
        n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL no_last_valid got %b want 1", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_vec !== want) $display("FAIL no_last_vec got %h want %h", bus.out_vec, want); else n_pass++;
        n_checks++; if (bus.err !== 1'b1) $display("FAIL no_last_err got %b want 1", bus.err); else n_pass++;
        send_word(32'h55, 1'b1, 1'b0);
        n_checks++; if (bus.err !== 1'b1) $display("FAIL last_on_x_err got %b want 1", bus.err); else n_pass++;
        n_checks++; if (bus.out_vec !== want) $display("FAIL last_on_x_vec got %h want %h", bus.out_vec, want); else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        logic [VW-1:0] want;
        want = 96'h00000006_00000005_00000004;
        bus.out_ready = 1'b1;
        err_seen = 1'b0;
        send_word(32'hEE, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        n_checks++; if (bus.out_vec !== 96'd0) $display("FAIL async_reset_vec got %h want 0", bus.out_vec); else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send_vec(32'd4, 32'd5, 32'd6, 1'b0);
        n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL rst_mid_valid got %b want 1", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_vec !== want) $display("FAIL rst_mid_vec got %h want %h", bus.out_vec, want); else n_pass++;
        @(posedge clk);
        #1;
        n_checks++; if (err_seen !== 1'b0) $display("FAIL rst_mid_err got %b want 0", err_seen); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int rcv;
        rcv = 0;
        exp_q.delete();
        fork
            begin
                for (int v = 0; v < 100; v++) begin
                    logic [CW-1:0] x, y, z;
                    logic neg;
                    x = $urandom; y = $urandom; z = $urandom;
                    neg = 1'($urandom_range(0, 1));
                    exp_q.push_back(pack(x, y, z, neg));
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    send_word(x, 1'b0, neg);
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    send_word(y, 1'b0, 1'($urandom_range(0, 1)));
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    send_word(z, 1'b1, 1'($urandom_range(0, 1)));
                end
            end
            begin
                logic [VW-1:0] want;
                for (int cyc = 0; cyc < 20000 && rcv < 100; cyc++) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                    if (bus.out_valid && bus.out_ready) begin
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            $display("FAIL b2b_extra got %h want none", bus.out_vec);
                        end else begin
                            want = exp_q.pop_front();
                            if (bus.out_vec !== want) $display("FAIL b2b_vec[%0d] got %h want %h", rcv, bus.out_vec, want);
                            else n_pass++;
                        end
                        rcv++;
                    end
                end
            end
        join
        n_checks++; if (rcv != 100) $display("FAIL b2b_count got %0d want 100", rcv); else n_pass++;
        n_checks++; if (exp_q.size() != 0) $display("FAIL b2b_leftover got %0d want 0", exp_q.size()); else n_pass++;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        err_seen = 1'b0;
        test_reset();
        test_basic();
        test_negate();
        test_stall();
        test_framing();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
